// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signals of the sprite-DMA controller/arbiter.
// Combinational pass-through bundle; cpu_rdy is the only backpressure (halts the CPU).
`timescale 1ns/1ps
interface oam_dma_ctrl_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic        bus_rw;
    logic [7:0]  bus_din;
    logic        busy;

    modport master (
        output cpu_a, cpu_dout, cpu_rw, bus_din,
        input  cpu_rdy, bus_a, bus_dout, bus_rw, busy
    );

    modport slave (
        input  cpu_a, cpu_dout, cpu_rw, bus_din,
        output cpu_rdy, bus_a, bus_dout, bus_rw, busy
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies one page to the OAM port.
// Stall of 513/514 cycles (+1 per CPU write seen while halting); cpu_rdy=0 holds the CPU off.
`timescale 1ns/1ps
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_RD,
        S_WR
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
    logic       r_parity;
    logic [7:0] w_page_nxt;
    logic [7:0] w_idx_nxt;
    logic [7:0] w_latch_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_latch  <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_page   <= w_page_nxt;
            r_idx    <= w_idx_nxt;
            r_latch  <= w_latch_nxt;
            r_parity <= ~r_parity;
        end
    end

    // Trigger is decoded from the CPU pins only, so DMA-issued writes can never retrigger.
    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_idx_nxt   = r_idx;
        w_latch_nxt = r_latch;
        unique case (r_state)
            S_IDLE: begin
                if (!bus.cpu_rw && bus.cpu_a == DMA_REG_ADDR) begin
                    w_page_nxt  = bus.cpu_dout;
                    w_idx_nxt   = 8'h00;
                    w_state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                // the 6502 only stops on a read cycle; odd parity lets RD start at once
                if (bus.cpu_rw) begin
                    w_state_nxt = r_parity ? S_RD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                w_state_nxt = S_RD;
            end
            S_RD: begin
                w_latch_nxt = bus.bus_din;
                w_state_nxt = S_WR;
            end
            S_WR: begin
                w_idx_nxt   = r_idx + 8'd1;
                w_state_nxt = (r_idx == 8'hFF) ? S_IDLE : S_RD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.bus_a    = bus.cpu_a;
        bus.bus_dout = bus.cpu_dout;
        bus.bus_rw   = bus.cpu_rw;
        unique case (r_state)
            S_ALIGN: begin
                bus.bus_rw = 1'b1;
            end
            S_RD: begin
                bus.bus_a    = {r_page, r_idx};
                bus.bus_dout = r_latch;
                bus.bus_rw   = 1'b1;
            end
            S_WR: begin
                bus.bus_a    = OAM_DATA_ADDR;
                bus.bus_dout = r_latch;
                bus.bus_rw   = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdy = (r_state == S_IDLE);
    assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: stall length, RD/WR alternation, OAM data, page wrap, resets.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_ctrl_if bif();

    oam_dma_ctrl #(
        .DMA_REG_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    assign bif.bus_din = mem_val(bif.bus_a);

    // cycles since reset release; bit 0 is the controller's parity in the current cycle
    logic [31:0] cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    int errors = 0;
    int checks = 0;

    int          stall, rd_n, wr_n, pass_n, seq_err, abort_err;
    logic [15:0] last_rd_a;
    bit          saw_zero, timeout, aborted, end_ok;

    task automatic do_transfer(input logic [7:0] page, input int extra,
                               input logic want_par, input int abort_wr);
        int k;
        bit last_was_rd;
        bit done;
        logic [31:0] t;
        stall = 0; rd_n = 0; wr_n = 0; pass_n = 0; seq_err = 0; abort_err = 0;
        last_rd_a = 16'h0000; saw_zero = 0; timeout = 0; aborted = 0; end_ok = 0;
        k = 0; last_was_rd = 0; done = 0;
        @(posedge clk); #1;
        t = cyc + 32'd1 + 32'(extra);
        while (t[0] !== want_par) begin
            @(posedge clk); #1;
            t = cyc + 32'd1 + 32'(extra);
        end
        bif.cpu_a = 16'h4014; bif.cpu_rw = 1'b0; bif.cpu_dout = page;
        @(negedge clk);
        if (bif.cpu_rdy !== 1'b1 || bif.bus_a !== 16'h4014 || bif.bus_rw !== 1'b0) seq_err++;
        for (int c = 0; c < 800 && !done && !aborted; c++) begin
            @(posedge clk); #1;
            if (k < extra) begin
                // first held write re-hits the DMA register and must be ignored
                bif.cpu_a    = (k == 0) ? 16'h4014 : 16'h0300 + 16'(k);
                bif.cpu_rw   = 1'b0;
                bif.cpu_dout = 8'h77 + 8'(k);
            end else begin
                bif.cpu_a = 16'h8000; bif.cpu_rw = 1'b1; bif.cpu_dout = 8'h00;
            end
            @(negedge clk);
            if (bif.cpu_rdy === 1'b1) begin
                done = 1;
                end_ok = (bif.busy === 1'b0 && bif.bus_a === 16'h8000 && bif.bus_rw === 1'b1);
            end else begin
                stall++;
                if (bif.busy !== 1'b1) seq_err++;
                if (k < extra) begin
                    if (bif.bus_a !== bif.cpu_a || bif.bus_rw !== 1'b0 ||
                        bif.bus_dout !== bif.cpu_dout) seq_err++;
                    k++;
                end else if (bif.bus_a === 16'h2004 && bif.bus_rw === 1'b0) begin
                    if (!last_was_rd) seq_err++;
                    if (bif.bus_dout !== mem_val({page, wr_n[7:0]})) seq_err++;
                    wr_n++;
                    last_was_rd = 0;
                    if (wr_n == abort_wr) begin
                        rst = 1'b1;
                        #1;
                        if (bif.cpu_rdy !== 1'b1 || bif.busy !== 1'b0 ||
                            bif.bus_a !== 16'h8000 || bif.bus_rw !== 1'b1) abort_err++;
                        aborted = 1;
                    end
                end else if (bif.bus_rw === 1'b1 && bif.bus_a !== 16'h8000) begin
                    if (last_was_rd) seq_err++;
                    if (bif.bus_a !== {page, rd_n[7:0]}) seq_err++;
                    if (bif.bus_a === 16'h0000) saw_zero = 1;
                    last_rd_a = bif.bus_a;
                    rd_n++;
                    last_was_rd = 1;
                end else if (bif.bus_a === 16'h8000 && bif.bus_rw === 1'b1 && rd_n == 0) begin
                    pass_n++;
                end else begin
                    seq_err++;
                end
            end
        end
        if (!done && !aborted) timeout = 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bif.cpu_a = 16'h1234; bif.cpu_rw = 1'b1; bif.cpu_dout = 8'h3C;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bif.cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", bif.cpu_rdy); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
        checks++; if (bif.bus_a !== 16'h1234) begin errors++; $display("FAIL reset_bus_a: got %h want 1234", bif.bus_a); end
        checks++; if (bif.bus_rw !== 1'b1) begin errors++; $display("FAIL reset_bus_rw: got %b want 1", bif.bus_rw); end
        checks++; if (bif.bus_dout !== 8'h3C) begin errors++; $display("FAIL reset_bus_dout: got %h want 3c", bif.bus_dout); end
        bif.cpu_rw = 1'b0; #1;
        checks++; if (bif.bus_rw !== 1'b0) begin errors++; $display("FAIL reset_rw_follow: got %b want 0", bif.bus_rw); end
        bif.cpu_rw = 1'b1; bif.cpu_a = 16'h8000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_transfer(input string name, input logic [7:0] page, input int extra,
                                 input logic want_par, input int want_stall, input int want_pass);
        do_transfer(page, extra, want_par, 0);
        checks++; if (timeout) begin errors++; $display("FAIL %s_timeout: transfer did not end in 800 cycles", name); end
        checks++; if (stall != want_stall) begin errors++; $display("FAIL %s_stall: got %0d want %0d", name, stall, want_stall); end
        checks++; if (pass_n != want_pass) begin errors++; $display("FAIL %s_halt_align: got %0d want %0d", name, pass_n, want_pass); end
        checks++; if (rd_n != 256 || wr_n != 256) begin errors++; $display("FAIL %s_counts: got rd=%0d wr=%0d want 256/256", name, rd_n, wr_n); end
        checks++; if (seq_err != 0) begin errors++; $display("FAIL %s_sequence: got %0d bad cycles want 0", name, seq_err); end
        checks++; if (!end_ok) begin errors++; $display("FAIL %s_release: got end_ok=%0d want 1", name, end_ok); end
    endtask

    task automatic test_page_boundary;
        test_transfer("page_ff", 8'hFF, 0, 1'b1, 513, 1);
        checks++; if (last_rd_a !== 16'hFFFF) begin errors++; $display("FAIL page_ff_last_rd: got %h want ffff", last_rd_a); end
        checks++; if (saw_zero) begin errors++; $display("FAIL page_ff_wrap: got DMA address 0000 want none"); end
    endtask

    task automatic test_reset_mid;
        do_transfer(8'h02, 0, 1'b1, 100);
        checks++; if (!aborted) begin errors++; $display("FAIL mid_reset_reached: got aborted=%0d want 1", aborted); end
        checks++; if (abort_err != 0) begin errors++; $display("FAIL mid_reset_idle: got %0d bad outputs want 0", abort_err); end
        checks++; if (seq_err != 0 || wr_n != 100) begin errors++; $display("FAIL mid_reset_prefix: got seq=%0d wr=%0d want 0/100", seq_err, wr_n); end
        @(negedge clk);
        rst = 1'b0;
        test_transfer("after_reset", 8'h02, 0, 1'b1, 513, 1);
    endtask

    initial begin
        bif.cpu_a = 16'h8000; bif.cpu_rw = 1'b1; bif.cpu_dout = 8'h00;
        test_reset();
        test_transfer("even", 8'h02, 0, 1'b0, 514, 2);
        test_transfer("odd", 8'h02, 0, 1'b1, 513, 1);
        test_transfer("halt_wr", 8'h02, 2, 1'b1, 515, 1);
        test_page_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
